hist_frame_receiver: RTL

Consumes the 64-bin histogram dump stream that the histogramming core emits when any bin saturates (64 consecutive valid beats of 3-bit counts, `last` on bin 63). It accumulates each frame into 64 wider saturating accumulators and tracks per-frame peak statistics, frame count and total sample count. It also checks framing and serves a registered random-access readout port. It sits directly downstream of the histogramming core and has no backpressure path to it.

---
 rtl/hist_frame_receiver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hist_frame_receiver.sv
// Receives 64-bin histogram dump frames, accumulates them into saturating
// per-bin accumulators, tracks per-frame statistics and serves a registered readout.
//
// state | meaning
// IDLE  | waiting for bin 0 of a new frame
// RECV  | receiving bins 1..NUM_BINS-1, idx holds the next bin index
// DRAIN | overrun seen, discarding beats until last
module hist_frame_receiver #(
  parameter int NUM_BINS = 64,
  parameter int CNT_W    = 3,
  parameter int ACC_W    = 8,
  localparam int IDX_W   = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_data,
  input  logic             in_last,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [ACC_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             frame_done,
  output logic [7:0]       frame_count,
  output logic [15:0]      total,
  output logic [IDX_W-1:0] peak_bin,
  output logic [CNT_W-1:0] peak_val,
  output logic             err
);

  localparam int SUM_W = CNT_W + IDX_W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc [NUM_BINS];
  logic [SUM_W-1:0] frame_sum;
  logic [CNT_W-1:0] run_peak_val;
  logic [IDX_W-1:0] run_peak_bin;

  logic             accept;
  logic             first;
  logic             is_last_bin;
  logic             clean;
  logic             beat_gt;
  logic [IDX_W-1:0] bin;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic [SUM_W-1:0] new_sum;
  logic [CNT_W-1:0] new_peak_val;
  logic [IDX_W-1:0] new_peak_bin;
  logic [16:0]      tot_sum;

  always_comb begin
    accept       = in_valid && !clr && (state != ST_DRAIN);
    first        = (state == ST_IDLE);
    bin          = first ? '0 : idx;
    is_last_bin  = (idx == IDX_W'(NUM_BINS - 1));
    clean        = accept && (state == ST_RECV) && in_last && is_last_bin;
    acc_sum      = {1'b0, acc[bin]} + {{(ACC_W + 1 - CNT_W){1'b0}}, in_data};
    acc_next     = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    // Strict compare keeps the lowest index on ties.
    beat_gt      = first || (in_data > run_peak_val);
    new_peak_val = beat_gt ? in_data : run_peak_val;
    new_peak_bin = beat_gt ? bin : run_peak_bin;
    new_sum      = first ? {{IDX_W{1'b0}}, in_data}
                         : frame_sum + {{IDX_W{1'b0}}, in_data};
    tot_sum      = {1'b0, total} + {{(17 - SUM_W){1'b0}}, new_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
    end else if (accept) begin
      acc[bin] <= acc_next;
    end
  end

  // Non-blocking read of acc gives the pre-update / pre-clear value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= acc[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sum    <= '0;
      run_peak_val <= '0;
      run_peak_bin <= '0;
    end else if (accept) begin
      frame_sum    <= new_sum;
      run_peak_val <= new_peak_val;
      run_peak_bin <= new_peak_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      total       <= '0;
      peak_bin    <= '0;
      peak_val    <= '0;
    end else if (clr) begin
      state       <= ST_IDLE;
      idx         <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      total       <= '0;
      peak_bin    <= '0;
      peak_val    <= '0;
    end else begin
      frame_done <= clean;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_last) begin
              err <= 1'b1;
            end else begin
              state <= ST_RECV;
              idx   <= IDX_W'(1);
            end
          end
        end
        ST_RECV: begin
          if (in_valid) begin
            if (in_last) begin
              state <= ST_IDLE;
              idx   <= '0;
              if (!is_last_bin) err <= 1'b1;
            end else if (is_last_bin) begin
              state <= ST_DRAIN;
              idx   <= '0;
              err   <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (in_valid && in_last) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
      if (clean) begin
        if (frame_count != 8'hff) frame_count <= frame_count + 8'd1;
        total    <= tot_sum[16] ? 16'hffff : tot_sum[15:0];
        peak_bin <= new_peak_bin;
        peak_val <= new_peak_val;
      end
    end
  end

endmodule
